// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back arbiter.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    // Register 0 is hard-wired to zero and is never tracked by the scoreboard
    localparam logic [ADDR_W-1:0] ZERO_REG = {ADDR_W{1'b0}};

    // Producer identity, used to remember who won the last transfer
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } requester_e;

endpackage

// File: rtl/regfile_wb_arbiter_checker.sv
// Property checks for the write-back arbiter, kept apart from the datapath.
module regfile_wb_arbiter_checker #(
    parameter int NUM_REGS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_alu_gnt,
    input  logic                i_mem_gnt,
    input  logic                i_reg_write,
    input  logic [NUM_REGS-1:0] i_busy_vec
);

    // Never two grants in the same cycle
    a_one_grant: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_alu_gnt && i_mem_gnt));

    // Register 0 is never marked busy
    a_zero_clean: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !i_busy_vec[0]);

    // A register-file write is always the result of a grant one cycle earlier
    a_write_after_grant: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_reg_write |-> $past(i_alu_gnt || i_mem_gnt));

endmodule

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. Bit 0 is the ALU, bit 1 is the load path.
// Grants are combinational; the last winner is remembered so that under
// contention the other side wins next.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    import regfile_pkg::*;

    requester_e r_last_grant;
    logic [1:0] w_gnt;

    // Pick the winner from the current requests and the last winner
    always_comb begin
        w_gnt = 2'b00;
        if (!rst_n) begin
            w_gnt = 2'b00;
        end else begin
            case (req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = (r_last_grant == REQ_MEM) ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign gnt = w_gnt;

    // Remember the winner only when a transfer actually completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= REQ_MEM;
        end else if (advance && (w_gnt != 2'b00)) begin
            r_last_grant <= w_gnt[1] ? REQ_MEM : REQ_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and scoreboard for the 8 x 16-bit register file.
// Shares the single write port between the ALU and load write-back stages,
// and tracks in-flight destinations so decode can stall on hazards.
module regfile_wb_arbiter #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                AluReq,
    input  logic [ADDR_W-1:0]   AluAddr,
    input  logic [DATA_W-1:0]   AluData,
    output logic                AluGnt,
    input  logic                MemReq,
    input  logic [ADDR_W-1:0]   MemAddr,
    input  logic [DATA_W-1:0]   MemData,
    output logic                MemGnt,
    input  logic                ReserveEn,
    input  logic [ADDR_W-1:0]   ReserveAddr,
    input  logic [ADDR_W-1:0]   ReadAddr1,
    input  logic [ADDR_W-1:0]   ReadAddr2,
    input  logic [ADDR_W-1:0]   DstAddr,
    output logic                Hazard,
    output logic [NUM_REGS-1:0] BusyVec,
    output logic                RegWrite,
    output logic [ADDR_W-1:0]   RegWriteAddr,
    output logic [DATA_W-1:0]   RegWriteData,
    output logic                ProtoErr
);
    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] W_ZERO = ADDR_W'(ZERO_REG);

    logic [1:0]          w_req;
    logic [1:0]          w_gnt;
    logic                w_xfer;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_data;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_busy_next;
    logic                w_res_viol;
    logic                w_wr_viol;

    logic [NUM_REGS-1:0] r_busy;
    logic                r_reg_write;
    logic [ADDR_W-1:0]   r_reg_write_addr;
    logic [DATA_W-1:0]   r_reg_write_data;
    logic                r_proto_err;

    assign w_req = {MemReq, AluReq};

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_req),
        .advance (w_xfer),
        .gnt     (w_gnt)
    );

    assign AluGnt = w_gnt[0];
    assign MemGnt = w_gnt[1];

    // Steer the winning producer's address and data towards the write port
    always_comb begin
        w_xfer     = (w_gnt != 2'b00);
        w_win_addr = AluAddr;
        w_win_data = AluData;
        if (w_gnt[1]) begin
            w_win_addr = MemAddr;
            w_win_data = MemData;
        end else begin
            w_win_addr = AluAddr;
            w_win_data = AluData;
        end
    end

    // Scoreboard set/clear masks; register 0 is never tracked
    always_comb begin
        w_clr = {NUM_REGS{1'b0}};
        w_set = {NUM_REGS{1'b0}};
        if (w_xfer && (w_win_addr != W_ZERO)) begin
            w_clr[w_win_addr] = 1'b1;
        end else begin
            w_clr = {NUM_REGS{1'b0}};
        end
        if (ReserveEn && (ReserveAddr != W_ZERO)) begin
            w_set[ReserveAddr] = 1'b1;
        end else begin
            w_set = {NUM_REGS{1'b0}};
        end
    end

    // A new reservation wins over a completing write to the same register
    assign w_busy_next = (r_busy & ~w_clr) | w_set;

    // Protocol checks: double reservation, and a write nobody reserved
    always_comb begin
        w_res_viol = 1'b0;
        w_wr_viol  = 1'b0;
        if (ReserveEn && (ReserveAddr != W_ZERO)) begin
            w_res_viol = r_busy[ReserveAddr] && !w_clr[ReserveAddr];
        end else begin
            w_res_viol = 1'b0;
        end
        if (w_xfer && (w_win_addr != W_ZERO)) begin
            w_wr_viol = !r_busy[w_win_addr];
        end else begin
            w_wr_viol = 1'b0;
        end
    end

    // Scoreboard, register-file write port and sticky error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy           <= {NUM_REGS{1'b0}};
            r_reg_write      <= 1'b0;
            r_reg_write_addr <= {ADDR_W{1'b0}};
            r_reg_write_data <= {DATA_W{1'b0}};
            r_proto_err      <= 1'b0;
        end else begin
            r_busy      <= w_busy_next;
            r_reg_write <= w_xfer && (w_win_addr != W_ZERO);
            if (w_xfer) begin
                r_reg_write_addr <= w_win_addr;
                r_reg_write_data <= w_win_data;
            end
            if (w_res_viol || w_wr_viol) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign BusyVec      = r_busy;
    assign Hazard       = r_busy[ReadAddr1] | r_busy[ReadAddr2] | r_busy[DstAddr];
    assign RegWrite     = r_reg_write;
    assign RegWriteAddr = r_reg_write_addr;
    assign RegWriteData = r_reg_write_data;
    assign ProtoErr     = r_proto_err;

    regfile_wb_arbiter_checker #(
        .NUM_REGS (NUM_REGS)
    ) u_chk (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_alu_gnt   (AluGnt),
        .i_mem_gnt   (MemGnt),
        .i_reg_write (RegWrite),
        .i_busy_vec  (BusyVec)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, random traffic
// against a scoreboard model, and a hand-written contention sequence.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        AluReq, MemReq, AluGnt, MemGnt;
    logic [2:0]  AluAddr, MemAddr;
    logic [15:0] AluData, MemData;
    logic        ReserveEn;
    logic [2:0]  ReserveAddr, ReadAddr1, ReadAddr2, DstAddr;
    logic        Hazard;
    logic [7:0]  BusyVec;
    logic        RegWrite;
    logic [2:0]  RegWriteAddr;
    logic [15:0] RegWriteData;
    logic        ProtoErr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .AluReq(AluReq), .AluAddr(AluAddr), .AluData(AluData), .AluGnt(AluGnt),
        .MemReq(MemReq), .MemAddr(MemAddr), .MemData(MemData), .MemGnt(MemGnt),
        .ReserveEn(ReserveEn), .ReserveAddr(ReserveAddr),
        .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2), .DstAddr(DstAddr),
        .Hazard(Hazard), .BusyVec(BusyVec),
        .RegWrite(RegWrite), .RegWriteAddr(RegWriteAddr), .RegWriteData(RegWriteData),
        .ProtoErr(ProtoErr)
    );

    typedef struct {
        logic        rst;
        logic        ar;  logic [2:0] aa; logic [15:0] ad;
        logic        mr;  logic [2:0] ma; logic [15:0] md;
        logic        re;  logic [2:0] ra;
        logic [2:0]  r1;  logic [2:0] dst;
        logic        e_ag; logic e_mg; logic e_hz; logic [7:0] e_busy;
        logic        e_rw; logic [2:0] e_wa; logic [15:0] e_wd; logic e_pe;
    } vec_t;

    vec_t vq[$];

    // Reference model state
    logic [7:0]  m_busy;
    int          m_last;   // 0 = ALU won last, 1 = MEM won last
    logic        m_pe;
    logic        m_rw;
    logic [2:0]  m_wa;
    logic [15:0] m_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic add(input int rst, input int ar, input int aa, input int ad,
                       input int mr, input int ma, input int md,
                       input int re, input int ra, input int r1, input int dst,
                       input int eag, input int emg, input int ehz, input int ebusy,
                       input int erw, input int ewa, input int ewd, input int epe);
        vec_t v;
        v.rst = 1'(rst); v.ar = 1'(ar); v.aa = 3'(aa); v.ad = 16'(ad);
        v.mr = 1'(mr); v.ma = 3'(ma); v.md = 16'(md);
        v.re = 1'(re); v.ra = 3'(ra); v.r1 = 3'(r1); v.dst = 3'(dst);
        v.e_ag = 1'(eag); v.e_mg = 1'(emg); v.e_hz = 1'(ehz); v.e_busy = 8'(ebusy);
        v.e_rw = 1'(erw); v.e_wa = 3'(ewa); v.e_wd = 16'(ewd); v.e_pe = 1'(epe);
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        AluReq = 1'b0; AluAddr = 3'd0; AluData = 16'h0000;
        MemReq = 1'b0; MemAddr = 3'd0; MemData = 16'h0000;
        ReserveEn = 1'b0; ReserveAddr = 3'd0;
        ReadAddr1 = 3'd0; ReadAddr2 = 3'd0; DstAddr = 3'd0;
    endtask

    // Random target for a new write: a reserved register nobody else is writing, or r0
    function automatic logic [2:0] pick_target(input logic other_req, input logic [2:0] other_addr);
        logic [2:0] r;
        for (int t = 0; t < 8; t++) begin
            r = 3'($urandom_range(0, 7));
            if (r != 3'd0 && m_busy[r] && !(other_req && other_addr == r)) return r;
        end
        return 3'd0;
    endfunction

    // Apply one clock edge to the model, using the spec's rules directly
    task automatic model_edge(input logic ag, input logic mg);
        logic       x;
        logic [2:0] wa;
        logic [15:0] wd;
        x  = ag || mg;
        wa = ag ? AluAddr : MemAddr;
        wd = ag ? AluData : MemData;
        if (x && wa != 3'd0 && !m_busy[wa]) m_pe = 1'b1;
        if (ReserveEn && ReserveAddr != 3'd0 && m_busy[ReserveAddr] && !(x && wa == ReserveAddr))
            m_pe = 1'b1;
        if (x && wa != 3'd0) m_busy[wa] = 1'b0;
        if (ReserveEn && ReserveAddr != 3'd0) m_busy[ReserveAddr] = 1'b1;
        m_rw = x && (wa != 3'd0);
        if (x) begin
            m_wa = wa;
            m_wd = wd;
            m_last = ag ? 0 : 1;
        end
    endtask

    initial begin
        logic e_ag, e_mg, e_hz;
        int   waited;

        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk); @(posedge clk); #1;

        // ---------------- directed vector table ----------------
        //   rst ar aa ad       mr ma md      re ra r1 dst  ag mg hz busy  rw wa wd      pe
        add(0,  1,1,'hAAAA,  0,0,0,       0,0, 0,0,    0,0,0,'h00,  0,0,'h0000,0); // reset holds grants low
        add(1,  0,0,0,       0,0,0,       1,3, 3,0,    0,0,0,'h00,  0,0,'h0000,0); // reserve 3
        add(1,  1,3,'h1234,  0,0,0,       0,0, 3,0,    1,0,1,'h08,  1,3,'h1234,0); // same-cycle grant
        add(1,  0,0,0,       0,0,0,       0,0, 3,0,    0,0,0,'h00,  0,3,'h1234,0); // hazard drops, data holds
        add(0,  0,0,0,       0,0,0,       0,0, 0,0,    0,0,0,'h00,  0,0,'h0000,0); // reset
        add(1,  0,0,0,       0,0,0,       1,2, 0,0,    0,0,0,'h00,  0,0,'h0000,0);
        add(1,  0,0,0,       0,0,0,       1,5, 2,0,    0,0,1,'h04,  0,0,'h0000,0);
        add(1,  1,2,'h2222,  1,5,'h5555,  0,0, 2,5,    1,0,1,'h24,  1,2,'h2222,0); // ALU wins first tie
        add(1,  0,0,0,       1,5,'h5555,  0,0, 2,5,    0,1,1,'h20,  1,5,'h5555,0); // MEM next, no gap
        add(1,  0,0,0,       0,0,0,       0,0, 5,0,    0,0,0,'h00,  0,5,'h5555,0);
        add(1,  0,0,0,       0,0,0,       1,1, 0,0,    0,0,0,'h00,  0,5,'h5555,0);
        add(1,  0,0,0,       0,0,0,       1,2, 0,0,    0,0,0,'h02,  0,5,'h5555,0);
        add(1,  0,0,0,       0,0,0,       1,3, 0,0,    0,0,0,'h06,  0,5,'h5555,0);
        add(1,  0,0,0,       0,0,0,       1,4, 0,0,    0,0,0,'h0E,  0,5,'h5555,0);
        add(1,  0,0,0,       0,0,0,       1,5, 0,0,    0,0,0,'h1E,  0,5,'h5555,0);
        add(1,  0,0,0,       0,0,0,       1,6, 0,0,    0,0,0,'h3E,  0,5,'h5555,0);
        add(1,  1,1,'hA001,  1,4,'hB004,  0,0, 0,0,    1,0,0,'h7E,  1,1,'hA001,0); // alternation
        add(1,  1,2,'hA002,  1,4,'hB004,  0,0, 0,0,    0,1,0,'h7C,  1,4,'hB004,0);
        add(1,  1,2,'hA002,  1,5,'hB005,  0,0, 0,0,    1,0,0,'h6C,  1,2,'hA002,0);
        add(1,  1,3,'hA003,  1,5,'hB005,  0,0, 0,0,    0,1,0,'h68,  1,5,'hB005,0);
        add(1,  1,3,'hA003,  1,6,'hB006,  0,0, 0,0,    1,0,0,'h48,  1,3,'hA003,0);
        add(1,  0,0,0,       1,6,'hB006,  0,0, 0,0,    0,1,0,'h40,  1,6,'hB006,0);
        add(1,  0,0,0,       1,0,'hFFFF,  0,0, 0,0,    0,1,0,'h00,  0,0,'hFFFF,0); // write to r0
        add(1,  0,0,0,       0,0,0,       0,0, 0,0,    0,0,0,'h00,  0,0,'hFFFF,0);
        add(1,  0,0,0,       0,0,0,       1,4, 0,0,    0,0,0,'h00,  0,0,'hFFFF,0);
        add(1,  1,4,'h4444,  0,0,0,       1,4, 4,0,    1,0,1,'h10,  1,4,'h4444,0); // set wins over clear
        add(1,  0,0,0,       0,0,0,       0,0, 0,4,    0,0,1,'h10,  0,4,'h4444,0);
        add(1,  0,0,0,       0,0,0,       1,6, 4,0,    0,0,1,'h10,  0,4,'h4444,0);
        add(1,  0,0,0,       0,0,0,       1,6, 0,0,    0,0,0,'h50,  0,4,'h4444,1); // double reserve
        add(1,  1,7,'h7777,  0,0,0,       0,0, 0,0,    1,0,0,'h50,  1,7,'h7777,1); // unreserved write
        add(0,  1,1,'h1111,  0,0,0,       0,0, 0,0,    0,0,0,'h50,  0,0,'h0000,0); // reset mid-request
        add(1,  0,0,0,       0,0,0,       0,0, 0,0,    0,0,0,'h00,  0,0,'h0000,0);

        foreach (vq[i]) begin
            rst_n = vq[i].rst;
            AluReq = vq[i].ar; AluAddr = vq[i].aa; AluData = vq[i].ad;
            MemReq = vq[i].mr; MemAddr = vq[i].ma; MemData = vq[i].md;
            ReserveEn = vq[i].re; ReserveAddr = vq[i].ra;
            ReadAddr1 = vq[i].r1; ReadAddr2 = 3'd0; DstAddr = vq[i].dst;
            #2;
            chk($sformatf("row%0d AluGnt", i),  32'(AluGnt),  32'(vq[i].e_ag));
            chk($sformatf("row%0d MemGnt", i),  32'(MemGnt),  32'(vq[i].e_mg));
            chk($sformatf("row%0d Hazard", i),  32'(Hazard),  32'(vq[i].e_hz));
            chk($sformatf("row%0d BusyVec", i), 32'(BusyVec), 32'(vq[i].e_busy));
            @(posedge clk); #1;
            chk($sformatf("row%0d RegWrite", i),     32'(RegWrite),     32'(vq[i].e_rw));
            chk($sformatf("row%0d RegWriteAddr", i), 32'(RegWriteAddr), 32'(vq[i].e_wa));
            chk($sformatf("row%0d RegWriteData", i), 32'(RegWriteData), 32'(vq[i].e_wd));
            chk($sformatf("row%0d ProtoErr", i),     32'(ProtoErr),     32'(vq[i].e_pe));
        end
        rst_n = 1'b1;
        idle_inputs();

        // ---------------- random traffic against the model ----------------
        m_busy = 8'h00; m_last = 1; m_pe = 1'b0; m_rw = 1'b0; m_wa = 3'd0; m_wd = 16'h0000;
        for (int c = 0; c < 400; c++) begin
            if (!AluReq && $urandom_range(0, 2) == 0) begin
                AluAddr = pick_target(MemReq, MemAddr);
                AluData = 16'($urandom);
                AluReq  = 1'b1;
            end
            if (!MemReq && $urandom_range(0, 2) == 0) begin
                MemAddr = pick_target(AluReq, AluAddr);
                MemData = 16'($urandom);
                MemReq  = 1'b1;
            end
            ReserveAddr = 3'($urandom_range(0, 7));
            ReserveEn   = ($urandom_range(0, 1) == 1) && ReserveAddr != 3'd0 && !m_busy[ReserveAddr];
            ReadAddr1 = 3'($urandom_range(0, 7));
            ReadAddr2 = 3'($urandom_range(0, 7));
            DstAddr   = 3'($urandom_range(0, 7));
            #2;
            e_ag = AluReq && (!MemReq || m_last == 1);
            e_mg = MemReq && (!AluReq || m_last == 0);
            e_hz = m_busy[ReadAddr1] | m_busy[ReadAddr2] | m_busy[DstAddr];
            chk($sformatf("rnd%0d AluGnt", c),  32'(AluGnt),  32'(e_ag));
            chk($sformatf("rnd%0d MemGnt", c),  32'(MemGnt),  32'(e_mg));
            chk($sformatf("rnd%0d Hazard", c),  32'(Hazard),  32'(e_hz));
            chk($sformatf("rnd%0d BusyVec", c), 32'(BusyVec), 32'(m_busy));
            model_edge(e_ag, e_mg);
            @(posedge clk); #1;
            chk($sformatf("rnd%0d RegWrite", c), 32'(RegWrite), 32'(m_rw));
            chk($sformatf("rnd%0d RegWriteAddr", c), 32'(RegWriteAddr), 32'(m_wa));
            chk($sformatf("rnd%0d RegWriteData", c), 32'(RegWriteData), 32'(m_wd));
            chk($sformatf("rnd%0d ProtoErr", c), 32'(ProtoErr), 32'(m_pe));
            if (e_ag) AluReq = 1'b0;
            if (e_mg) MemReq = 1'b0;
            ReserveEn = 1'b0;
        end

        // ---------------- hand sequence: loser waits exactly one cycle ----------------
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ReserveEn = 1'b1; ReserveAddr = 3'd3;
        @(posedge clk); #1;
        ReserveEn = 1'b0;
        AluReq = 1'b1; AluAddr = 3'd3; AluData = 16'hBEEF;
        MemReq = 1'b1; MemAddr = 3'd0; MemData = 16'h0F0F;
        #2;
        waited = 0;
        while (!AluGnt && waited < 4) begin
            @(posedge clk); #3;
            waited++;
        end
        if (waited >= 4) chk("seq alu grant timeout", 32'(AluGnt), 32'd1);
        else chk("seq alu wait cycles", 32'(waited), 32'd0);
        chk("seq mem held off", 32'(MemGnt), 32'd0);
        @(posedge clk); #1;
        AluReq = 1'b0;
        chk("seq RegWrite alu", 32'(RegWrite), 32'd1);
        chk("seq RegWriteAddr alu", 32'(RegWriteAddr), 32'd3);
        chk("seq RegWriteData alu", 32'(RegWriteData), 32'h0000BEEF);
        chk("seq BusyVec cleared", 32'(BusyVec), 32'd0);
        #2;
        chk("seq mem granted next", 32'(MemGnt), 32'd1);
        @(posedge clk); #1;
        MemReq = 1'b0;
        chk("seq RegWrite r0", 32'(RegWrite), 32'd0);
        chk("seq RegWriteData r0", 32'(RegWriteData), 32'h00000F0F);
        chk("seq ProtoErr clean", 32'(ProtoErr), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
